// File: rtl/mips_mdu_pkg.sv
// Shared encodings for the MIPS multiply/divide unit.
package mips_mdu_pkg;

  localparam int OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_FIXUP = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mips_mdu_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
interface mips_mdu_if
  import mips_mdu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic                start;
  logic [OP_WIDTH-1:0] op;
  logic [WIDTH-1:0]    srca;
  logic [WIDTH-1:0]    srcb;
  logic                kill;
  logic                busy;
  logic                done;
  logic                divzero;
  logic [WIDTH-1:0]    hi;
  logic [WIDTH-1:0]    lo;

  modport master (
    output start, op, srca, srcb, kill,
    input  busy, done, divzero, hi, lo
  );

  modport slave (
    input  start, op, srca, srcb, kill,
    output busy, done, divzero, hi, lo
  );
endinterface

// File: rtl/mips_mdu_step.sv
// One iteration bit: shift-add multiply step or restoring divide step on {acc, q}.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] q_out
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  always_comb begin
    sum       = '0;
    rem_shift = '0;
    diff      = '0;
    acc_out   = acc_in;
    q_out     = q_in;
    if (!is_div) begin
      // Multiplier LSB selects the add; the carry shifts back into acc.
      sum     = {1'b0, acc_in} + (q_in[0] ? {1'b0, operand} : '0);
      acc_out = sum[WIDTH:1];
      q_out   = {sum[0], q_in[WIDTH-1:1]};
    end else begin
      rem_shift = {acc_in, q_in[WIDTH-1]};
      diff      = rem_shift - {1'b0, operand};
      if (rem_shift >= {1'b0, operand}) begin
        acc_out = diff[WIDTH-1:0];
        q_out   = {q_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = rem_shift[WIDTH-1:0];
        q_out   = {q_in[WIDTH-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/mips_mdu.sv
// Iterative MIPS HI/LO multiply/divide unit, UNROLL bits retired per ITER cycle.
module mips_mdu
  import mips_mdu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input logic      clk,
  input logic      reset,
  mips_mdu_if.slave bus
);
  localparam int ITERS = WIDTH / UNROLL;
  localparam int CW    = $clog2(ITERS) + 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  mdu_state_e state, state_next;
  mdu_op_e    op_in;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, q, operand, srca_saved;
  logic [WIDTH-1:0] hi, lo;
  logic             is_div, neg_q, neg_r, div_by_zero;
  logic             done, divzero;
  logic             accept, move_hi, move_lo, iter_en, write_en;

  logic [WIDTH-1:0] acc_chain [UNROLL+1];
  logic [WIDTH-1:0] q_chain   [UNROLL+1];

  logic             signed_op;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign op_in = mdu_op_e'(bus.op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    move_hi    = 1'b0;
    move_lo    = 1'b0;
    iter_en    = 1'b0;
    write_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && !bus.kill) begin
          case (op_in)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              accept     = 1'b1;
              state_next = ST_ITER;
            end
            OP_MTHI: move_hi = 1'b1;
            OP_MTLO: move_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_ITER: begin
        if (bus.kill) state_next = ST_IDLE;
        else begin
          iter_en = 1'b1;
          if (count == LAST) state_next = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        state_next = ST_IDLE;
        if (!bus.kill) write_en = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign acc_chain[0] = acc;
  assign q_chain[0]   = q;

  generate
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
      mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_in  (acc_chain[gi]),
        .q_in    (q_chain[gi]),
        .operand (operand),
        .acc_out (acc_chain[gi+1]),
        .q_out   (q_chain[gi+1])
      );
    end
  endgenerate

  // The iteration works on magnitudes; signs are restored in FIXUP.
  always_comb begin
    signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
    a_abs     = (signed_op && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
    b_abs     = (signed_op && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;
  end

  always_comb begin
    product = {acc, q};
    if (neg_q) product = -product;
    res_hi = product[2*WIDTH-1:WIDTH];
    res_lo = product[WIDTH-1:0];
    if (is_div) begin
      if (div_by_zero) begin
        res_hi = srca_saved;
        res_lo = '1;
      end else begin
        res_hi = neg_r ? -acc : acc;
        res_lo = neg_q ? -q : q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      acc         <= '0;
      q           <= '0;
      operand     <= '0;
      srca_saved  <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      divzero     <= 1'b0;
    end else begin
      done    <= write_en;
      divzero <= write_en && is_div && div_by_zero;
      if (accept) begin
        count       <= '0;
        acc         <= '0;
        q           <= a_abs;
        operand     <= b_abs;
        srca_saved  <= bus.srca;
        is_div      <= bus.op[1];
        neg_q       <= signed_op && (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
        neg_r       <= signed_op && bus.srca[WIDTH-1];
        div_by_zero <= bus.op[1] && (bus.srcb == '0);
      end
      if (iter_en) begin
        acc   <= acc_chain[UNROLL];
        q     <= q_chain[UNROLL];
        count <= count + 1'b1;
      end
      if (move_hi)  hi <= bus.srca;
      if (move_lo)  lo <= bus.srca;
      if (write_en) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = done;
  assign bus.divzero = divzero;
  assign bus.hi      = hi;
  assign bus.lo      = lo;
endmodule

// File: tb/tb_mips_mdu.sv
// Directed-vector bench for mips_mdu: UNROLL=1 and UNROLL=4 instances side by side.
module tb_mips_mdu;
  import mips_mdu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_mdu_if #(.WIDTH(32)) bus1();
  mips_mdu_if #(.WIDTH(32)) bus4();

  mips_mdu #(.WIDTH(32), .UNROLL(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  mips_mdu #(.WIDTH(32), .UNROLL(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  int errors = 0;
  int checks = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue a long op on bus1, check busy and the held HI/LO mid-flight, return latency.
  task automatic run_op1(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] old_hi,
                         input logic [31:0] old_lo, output int lat);
    @(negedge clk);
    bus1.start = 1'b1; bus1.op = op; bus1.srca = a; bus1.srcb = b;
    @(negedge clk);
    bus1.start = 1'b0;
    lat = 0;
    check_value({name, " busy"}, 64'(bus1.busy), 64'd1);
    while (!bus1.done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 10) begin
        check_value({name, " hi held"}, 64'(bus1.hi), 64'(old_hi));
        check_value({name, " lo held"}, 64'(bus1.lo), 64'(old_lo));
      end
    end
    $display("op %s a=%h b=%h -> hi=%h lo=%h divzero=%0d latency=%0d",
             name, a, b, bus1.hi, bus1.lo, bus1.divzero, lat);
  endtask

  task automatic move_op1(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic kill_in);
    @(negedge clk);
    bus1.start = 1'b1; bus1.op = op; bus1.srca = a; bus1.kill = kill_in;
    @(negedge clk);
    bus1.start = 1'b0; bus1.kill = 1'b0;
    $display("op %s a=%h kill=%0d -> hi=%h lo=%h busy=%0d", name, a, kill_in,
             bus1.hi, bus1.lo, bus1.busy);
  endtask

  initial begin
    int lat;
    int dones;
    bus1.start = 1'b0; bus1.op = '0; bus1.srca = '0; bus1.srcb = '0; bus1.kill = 1'b0;
    bus4.start = 1'b0; bus4.op = '0; bus4.srca = '0; bus4.srcb = '0; bus4.kill = 1'b0;

    repeat (2) @(negedge clk);
    check_value("reset hi", 64'(bus1.hi), 64'd0);
    check_value("reset lo", 64'(bus1.lo), 64'd0);
    check_value("reset busy", 64'(bus1.busy), 64'd0);
    check_value("reset done", 64'(bus1.done), 64'd0);
    check_value("reset divzero", 64'(bus1.divzero), 64'd0);
    reset = 1'b0;

    run_op1("MULT -3*7", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'h0, 32'h0, lat);
    check_value("mult latency", 64'(lat), 64'd33);
    check_value("mult hi", 64'(bus1.hi), 64'hFFFFFFFF);
    check_value("mult lo", 64'(bus1.lo), 64'hFFFFFFEB);
    check_value("mult divzero", 64'(bus1.divzero), 64'd0);
    check_value("mult busy at done", 64'(bus1.busy), 64'd0);

    run_op1("MULT -5*-6", OP_MULT, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFEB, lat);
    check_value("mult neg hi", 64'(bus1.hi), 64'd0);
    check_value("mult neg lo", 64'(bus1.lo), 64'h1E);

    run_op1("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h1E, lat);
    check_value("divu latency", 64'(lat), 64'd33);
    check_value("divu lo", 64'(bus1.lo), 64'hE);
    check_value("divu hi", 64'(bus1.hi), 64'h2);

    run_op1("DIV -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'h2, 32'hE, lat);
    check_value("div lo", 64'(bus1.lo), 64'hFFFFFFFD);
    check_value("div hi", 64'(bus1.hi), 64'hFFFFFFFF);
    check_value("div divzero", 64'(bus1.divzero), 64'd0);

    run_op1("DIV 5/0", OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, lat);
    check_value("div0 latency", 64'(lat), 64'd33);
    check_value("div0 lo", 64'(bus1.lo), 64'hFFFFFFFF);
    check_value("div0 hi", 64'(bus1.hi), 64'h5);
    check_value("div0 divzero", 64'(bus1.divzero), 64'd1);

    run_op1("DIV min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'hFFFFFFFF, lat);
    check_value("divmin lo", 64'(bus1.lo), 64'h80000000);
    check_value("divmin hi", 64'(bus1.hi), 64'h0);
    check_value("divmin divzero", 64'(bus1.divzero), 64'd0);

    // Same divide on the 4-bits-per-cycle instance.
    @(negedge clk);
    bus4.start = 1'b1; bus4.op = OP_DIVU; bus4.srca = 32'd100; bus4.srcb = 32'd7;
    @(negedge clk);
    bus4.start = 1'b0;
    lat = 0;
    while (!bus4.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    $display("op DIVU 100/7 unroll4 -> hi=%h lo=%h latency=%0d", bus4.hi, bus4.lo, lat);
    check_value("u4 latency", 64'(lat), 64'd9);
    check_value("u4 lo", 64'(bus4.lo), 64'hE);
    check_value("u4 hi", 64'(bus4.hi), 64'h2);

    move_op1("MTLO", OP_MTLO, 32'h1234, 1'b0);
    check_value("mtlo lo", 64'(bus1.lo), 64'h1234);
    check_value("mtlo hi", 64'(bus1.hi), 64'h0);
    check_value("mtlo busy", 64'(bus1.busy), 64'd0);
    check_value("mtlo done", 64'(bus1.done), 64'd0);

    // MULTU 2*3 with a DIVU issued mid-flight that must be ignored.
    @(negedge clk);
    bus1.start = 1'b1; bus1.op = OP_MULTU; bus1.srca = 32'd2; bus1.srcb = 32'd3;
    @(negedge clk);
    bus1.start = 1'b0;
    dones = 0; lat = 0;
    for (int n = 1; n <= 60; n++) begin
      if (n == 5) begin
        bus1.start = 1'b1; bus1.op = OP_DIVU; bus1.srca = 32'd100; bus1.srcb = 32'd7;
      end
      @(negedge clk);
      bus1.start = 1'b0;
      if (bus1.done) begin
        dones++;
        if (lat == 0) lat = n;
      end
    end
    $display("op MULTU 2*3 + ignored DIVU -> hi=%h lo=%h dones=%0d latency=%0d",
             bus1.hi, bus1.lo, dones, lat);
    check_value("busy-start dones", 64'(dones), 64'd1);
    check_value("busy-start latency", 64'(lat), 64'd33);
    check_value("multu lo", 64'(bus1.lo), 64'h6);
    check_value("multu hi", 64'(bus1.hi), 64'h0);

    move_op1("MTHI", OP_MTHI, 32'hABCD, 1'b0);
    check_value("mthi hi", 64'(bus1.hi), 64'hABCD);

    // Kill at cycle 10 of a MULT.
    @(negedge clk);
    bus1.start = 1'b1; bus1.op = OP_MULT; bus1.srca = 32'd9; bus1.srcb = 32'd9;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (9) @(negedge clk);
    bus1.kill = 1'b1;
    @(negedge clk);
    bus1.kill = 1'b0;
    check_value("kill busy", 64'(bus1.busy), 64'd0);
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus1.done) dones++;
    end
    $display("op MULT 9*9 killed -> hi=%h lo=%h dones=%0d", bus1.hi, bus1.lo, dones);
    check_value("kill dones", 64'(dones), 64'd0);
    check_value("kill hi", 64'(bus1.hi), 64'hABCD);
    check_value("kill lo", 64'(bus1.lo), 64'h6);

    move_op1("MTLO+kill", OP_MTLO, 32'h5555, 1'b1);
    check_value("kill mtlo lo", 64'(bus1.lo), 64'h6);
    move_op1("MULT+kill", OP_MULT, 32'h3, 1'b1);
    check_value("kill start busy", 64'(bus1.busy), 64'd0);
    move_op1("op110", 3'b110, 32'h7777, 1'b0);
    check_value("op110 busy", 64'(bus1.busy), 64'd0);
    check_value("op110 lo", 64'(bus1.lo), 64'h6);
    check_value("op110 hi", 64'(bus1.hi), 64'hABCD);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    bus1.start = 1'b1; bus1.op = OP_DIVU; bus1.srca = 32'd100; bus1.srcb = 32'd7;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_value("rst hi", 64'(bus1.hi), 64'd0);
    check_value("rst lo", 64'(bus1.lo), 64'd0);
    check_value("rst busy", 64'(bus1.busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus1.done) dones++;
    end
    $display("op DIVU reset mid-op -> hi=%h lo=%h dones=%0d", bus1.hi, bus1.lo, dones);
    check_value("rst dones", 64'(dones), 64'd0);
    check_value("rst busy after", 64'(bus1.busy), 64'd0);
    check_value("rst divzero", 64'(bus1.divzero), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_mdu.md
MIPS_MDU -- requirements
Module: mips_mdu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width.
REQ-002 The block SHALL have parameter UNROLL, default 1, giving the iteration bits retired per cycle; legal values are 1, 2 and 4, and UNROLL SHALL divide WIDTH.
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port reset  input  1  reset, asynchronous, active-high.
REQ-005 Port start  input  1  issue of op with srca/srcb, sampled on the rising edge.
REQ-006 Port op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
REQ-007 Port srca  input  WIDTH  multiplicand/dividend/move source.
REQ-008 Port srcb  input  WIDTH  multiplier/divisor.
REQ-009 Port kill  input  1  abort of in-flight op (pipeline flush).
REQ-010 Port busy  output  1  op in flight; pipeline stalls MFHI/MFLO/new MDU ops while high.
REQ-011 Port done  output  1  one-cycle pulse, hi/lo updated this edge.
REQ-012 Port divzero  output  1  set with done when the completed DIV/DIVU had srcb==0.
REQ-013 Port hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-014 FSM states SHALL be IDLE, ITER, FIXUP; start accepted only in IDLE with kill low.
REQ-015 MULT/MULTU/DIV/DIVU start SHALL move IDLE->ITER, latch |operands| (signed ops) or raw operands, and clear the iteration counter.
REQ-016 ITER SHALL last exactly WIDTH/UNROLL cycles: shift-add multiply or restoring divide, UNROLL bits per cycle, then ->FIXUP.
REQ-017 FIXUP SHALL last one cycle: negate product if signs differ (MULT); negate quotient if signs differ and give remainder the dividend's sign (DIV); write hi/lo; pulse done; ->IDLE.
REQ-018 Total latency start-edge to done SHALL be WIDTH/UNROLL+1 cycles; busy high from the edge after start through the FIXUP cycle inclusive.
REQ-019 hi/lo SHALL hold prior values until the FIXUP edge; intermediate state lives in separate working registers.
REQ-020 MTHI/MTLO SHALL write srca to hi/lo on the start edge, no busy, no done.
REQ-021 start while busy SHALL be ignored with no effect on the in-flight op.
REQ-022 kill in ITER or FIXUP SHALL return the FSM to IDLE next edge with hi/lo unchanged and no done; kill with start in IDLE SHALL suppress the start.
REQ-023 Divide by zero SHALL complete with normal latency: lo = all ones, hi = srca, divzero = 1.
REQ-024 DIV of most-negative by -1 SHALL give lo = most-negative, hi = 0, without a flag.
REQ-025 Ops 110/111 SHALL be ignored like no start.

Reset
REQ-026 reset SHALL force IDLE, counter 0, busy 0, done 0, divzero 0, hi 0, lo 0, asynchronously.
REQ-027 reset mid-op SHALL abandon the op; no done follows after reset release.

Structure
REQ-028 Package mips_mdu_pkg SHALL hold the op encoding enum, the FSM state enum and the op-width constant.
REQ-029 Sub-module mdu_step SHALL implement one combinational shift-add/restoring-subtract bit step, instantiated UNROLL times in a chain.

Verification (WIDTH=32, UNROLL=1 unless noted)
REQ-030 MULT srca=-3 srcb=7 -> done 33 cycles after start, hi=FFFFFFFF, lo=FFFFFFEB.
REQ-031 DIVU 100/7 -> lo=0000000E, hi=00000002; repeat with UNROLL=4 -> same results, done after 9 cycles.
REQ-032 DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV 5/0 -> lo=FFFFFFFF, hi=00000005, divzero=1.
REQ-033 MTLO 1234 -> lo=00001234 next edge; then MULTU 2*3 issued, second start DIVU at cycle 5 ignored -> lo=00000006, hi=0, one done only.
REQ-034 kill at cycle 10 of MULT -> busy low next edge, no done, hi/lo unchanged; reset asserted mid-DIV -> all outputs 0, no done after release.
